// File: rtl/ceas_alarma.sv
// Timekeeping and alarm core: prescaled hh:mm:ss counter, load-edge handling for
// time and alarm settings, and the ringer FSM with stop, snooze and ring timeout.
module ceas_alarma #(
  parameter int unsigned TICKS_PER_SEC  = 50000000,
  parameter int unsigned DURATA_SUNA    = 60,
  parameter int unsigned DURATA_AMANARE = 300
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] ore_in,
  input  logic [5:0] minute_in,
  input  logic       load_timp,
  input  logic       load_alarma,
  input  logic       alarma_en,
  input  logic       semnal_oprire,
  input  logic       semnal_amanare,
  output logic [4:0] ore,
  output logic [5:0] minute,
  output logic [5:0] secunde,
  output logic [4:0] ore_alarma,
  output logic [5:0] minute_alarma,
  output logic       sec_puls,
  output logic       sonerie
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_SEC - 1);
  localparam logic [8:0] SunaLast    = 9'(DURATA_SUNA - 1);
  localparam logic [8:0] AmanareLast = 9'(DURATA_AMANARE - 1);

  typedef enum logic [1:0] {StAsteptare, StSuna, StAmanat} state_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    ore_q, ore_d;
  logic [5:0]    minute_q, minute_d;
  logic [5:0]    secunde_q, secunde_d;
  logic [4:0]    ore_al_q;
  logic [5:0]    minute_al_q;
  logic          ld_timp_q, ld_timp_prev_q;
  logic          ld_alarma_q, ld_alarma_prev_q;
  logic          sec_puls_q;
  state_e        state_q;
  logic [8:0]    sec_ctr_q;
  logic          sonerie_q;

  logic in_valid, time_load, alarm_load, tick, advance, match;

  // Load decode, prescaler wrap and next time value; a time load overrides the tick.
  always_comb begin
    in_valid   = (ore_in <= 5'd23) && (minute_in <= 6'd59);
    time_load  = ld_timp_q & ~ld_timp_prev_q & in_valid;
    alarm_load = ld_alarma_q & ~ld_alarma_prev_q & in_valid;
    tick       = (presc_q == PrescLast);
    advance    = tick & ~time_load;

    presc_d   = presc_q + PW'(1);
    ore_d     = ore_q;
    minute_d  = minute_q;
    secunde_d = secunde_q;

    if (time_load) begin
      presc_d   = '0;
      ore_d     = ore_in;
      minute_d  = minute_in;
      secunde_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (secunde_q == 6'd59) begin
        secunde_d = '0;
        if (minute_q == 6'd59) begin
          minute_d = '0;
          ore_d    = (ore_q == 5'd23) ? 5'd0 : ore_q + 5'd1;
        end else begin
          minute_d = minute_q + 6'd1;
        end
      end else begin
        secunde_d = secunde_q + 6'd1;
      end
    end

    // Only a real advance can match; landing on the alarm time by a load does not ring.
    match = advance && alarma_en && (secunde_d == 6'd0) &&
            (minute_d == minute_al_q) && (ore_d == ore_al_q);
  end

  // Running time, prescaler, load-edge history and the second pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q          <= '0;
      ore_q            <= '0;
      minute_q         <= '0;
      secunde_q        <= '0;
      ld_timp_q        <= 1'b0;
      ld_timp_prev_q   <= 1'b0;
      ld_alarma_q      <= 1'b0;
      ld_alarma_prev_q <= 1'b0;
      sec_puls_q       <= 1'b0;
    end else begin
      presc_q          <= presc_d;
      ore_q            <= ore_d;
      minute_q         <= minute_d;
      secunde_q        <= secunde_d;
      ld_timp_q        <= load_timp;
      ld_timp_prev_q   <= ld_timp_q;
      ld_alarma_q      <= load_alarma;
      ld_alarma_prev_q <= ld_alarma_q;
      sec_puls_q       <= advance;
    end
  end

  // Stored alarm time; reloading does not disturb the ringer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ore_al_q    <= '0;
      minute_al_q <= '0;
    end else if (alarm_load) begin
      ore_al_q    <= ore_in;
      minute_al_q <= minute_in;
    end
  end

  // Ringer FSM; sonerie is registered alongside the state so it tracks StSuna exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StAsteptare;
      sec_ctr_q <= '0;
      sonerie_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAsteptare: begin
          if (match) begin
            state_q   <= StSuna;
            sec_ctr_q <= '0;
            sonerie_q <= 1'b1;
          end
        end
        StSuna: begin
          if (!alarma_en || semnal_oprire) begin
            state_q   <= StAsteptare;
            sonerie_q <= 1'b0;
          end else if (semnal_amanare) begin
            state_q   <= StAmanat;
            sec_ctr_q <= '0;
            sonerie_q <= 1'b0;
          end else if (advance) begin
            if (sec_ctr_q == SunaLast) begin
              state_q   <= StAsteptare;
              sonerie_q <= 1'b0;
            end else begin
              sec_ctr_q <= sec_ctr_q + 9'd1;
            end
          end
        end
        StAmanat: begin
          if (!alarma_en || semnal_oprire) begin
            state_q   <= StAsteptare;
            sonerie_q <= 1'b0;
          end else if (advance) begin
            if (sec_ctr_q == AmanareLast) begin
              state_q   <= StSuna;
              sec_ctr_q <= '0;
              sonerie_q <= 1'b1;
            end else begin
              sec_ctr_q <= sec_ctr_q + 9'd1;
            end
          end
        end
        default: begin
          state_q   <= StAsteptare;
          sonerie_q <= 1'b0;
        end
      endcase
    end
  end

  assign ore           = ore_q;
  assign minute        = minute_q;
  assign secunde       = secunde_q;
  assign ore_alarma    = ore_al_q;
  assign minute_alarma = minute_al_q;
  assign sec_puls      = sec_puls_q;
  assign sonerie       = sonerie_q;

endmodule

// File: tb/tb_ceas_alarma.sv
// Self-checking bench for ceas_alarma: directed scenarios plus randomized alarm
// episodes, all compared every cycle against a seconds-of-day reference model.
module tb_ceas_alarma;

  localparam int unsigned T = 4;
  localparam int unsigned D = 3;
  localparam int unsigned A = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] ore_in;
  logic [5:0] minute_in;
  logic       load_timp, load_alarma, alarma_en, semnal_oprire, semnal_amanare;
  logic [4:0] ore, ore_alarma;
  logic [5:0] minute, secunde, minute_alarma;
  logic       sec_puls, sonerie;

  always #5 clock = ~clock;

  ceas_alarma #(
    .TICKS_PER_SEC (T),
    .DURATA_SUNA   (D),
    .DURATA_AMANARE(A)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ore_in        (ore_in),
    .minute_in     (minute_in),
    .load_timp     (load_timp),
    .load_alarma   (load_alarma),
    .alarma_en     (alarma_en),
    .semnal_oprire (semnal_oprire),
    .semnal_amanare(semnal_amanare),
    .ore           (ore),
    .minute        (minute),
    .secunde       (secunde),
    .ore_alarma    (ore_alarma),
    .minute_alarma (minute_alarma),
    .sec_puls      (sec_puls),
    .sonerie       (sonerie)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time as seconds of day, alarm as minutes of day,
  // ringer as a mode with a count of seconds left.
  int m_tod, m_phase, m_alarm, m_mode, m_left;
  bit m_pulse, m_lt_r, m_lt_p, m_la_r, m_la_p;

  task automatic model_reset();
    m_tod = 0; m_phase = 0; m_alarm = 0; m_mode = 0; m_left = 0;
    m_pulse = 0; m_lt_r = 0; m_lt_p = 0; m_la_r = 0; m_la_p = 0;
  endtask

  task automatic model_edge();
    bit valid, tl, al, tick, adv, match;
    valid = (int'(ore_in) <= 23) && (int'(minute_in) <= 59);
    tl    = m_lt_r && !m_lt_p && valid;
    al    = m_la_r && !m_la_p && valid;
    tick  = (m_phase == T - 1);
    adv   = tick && !tl;
    if (tl) begin
      m_tod   = int'(ore_in) * 3600 + int'(minute_in) * 60;
      m_phase = 0;
    end else if (tick) begin
      m_tod   = (m_tod + 1) % 86400;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    m_pulse = adv;
    match = adv && alarma_en && (m_tod % 60 == 0) && (m_tod / 60 == m_alarm);
    case (m_mode)
      0: if (match) begin m_mode = 1; m_left = D; end
      1: begin
        if (!alarma_en || semnal_oprire) m_mode = 0;
        else if (semnal_amanare) begin m_mode = 2; m_left = A; end
        else if (adv) begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
      default: begin
        if (!alarma_en || semnal_oprire) m_mode = 0;
        else if (adv) begin
          m_left--;
          if (m_left == 0) begin m_mode = 1; m_left = D; end
        end
      end
    endcase
    if (al) m_alarm = int'(ore_in) * 60 + int'(minute_in);
    m_lt_p = m_lt_r; m_lt_r = load_timp;
    m_la_p = m_la_r; m_la_r = load_alarma;
  endtask

  task automatic compare_all();
    check_val("ore", 32'(ore), 32'(m_tod / 3600));
    check_val("minute", 32'(minute), 32'((m_tod / 60) % 60));
    check_val("secunde", 32'(secunde), 32'(m_tod % 60));
    check_val("ore_alarma", 32'(ore_alarma), 32'(m_alarm / 60));
    check_val("minute_alarma", 32'(minute_alarma), 32'(m_alarm % 60));
    check_val("sec_puls", 32'(sec_puls), 32'(m_pulse));
    check_val("sonerie", 32'(sonerie), 32'(m_mode == 1));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Leaves load_timp high after the load has landed.
  task automatic load_time(input int h, input int m);
    load_timp = 1'b0;
    step();
    ore_in    = 5'(h);
    minute_in = 6'(m);
    load_timp = 1'b1;
    step();
    step();
  endtask

  task automatic load_alarm(input int h, input int m);
    load_alarma = 1'b0;
    step();
    ore_in      = 5'(h);
    minute_in   = 6'(m);
    load_alarma = 1'b1;
    step();
    step();
    load_alarma = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ore_in = '0; minute_in = '0;
    load_timp = 0; load_alarma = 0; alarma_en = 0; semnal_oprire = 0; semnal_amanare = 0;
    #2;
    model_reset();
    compare_all();
    #6 reset = 1'b0;

    // Free-running count for one hour.
    run(T * 3600);
    check_val("t1_ore", 32'(ore), 32'd1);
    check_val("t1_minute", 32'(minute), 32'd0);
    check_val("t1_secunde", 32'(secunde), 32'd0);
    check_val("t1_puls", 32'(sec_puls), 32'd1);

    // Load 23:59, hold load high, wrap through midnight.
    load_time(23, 59);
    check_val("t2_load_ore", 32'(ore), 32'd23);
    check_val("t2_load_min", 32'(minute), 32'd59);
    run(T * 60);
    check_val("t2_wrap_ore", 32'(ore), 32'd0);
    check_val("t2_wrap_min", 32'(minute), 32'd0);
    check_val("t2_wrap_sec", 32'(secunde), 32'd0);

    // Out-of-range loads are ignored.
    load_time(24, 10);
    check_val("t3_bad_ore", 32'(ore), 32'd0);
    check_val("t3_bad_sec", 32'(secunde), 32'd0);
    load_time(5, 60);
    check_val("t3_bad_min_ore", 32'(ore), 32'd0);
    load_timp = 1'b0;
    run(8);

    // Alarm 07:30, ring and timeout.
    alarma_en = 1'b1;
    load_alarm(7, 30);
    check_val("t4_al_ore", 32'(ore_alarma), 32'd7);
    check_val("t4_al_min", 32'(minute_alarma), 32'd30);
    load_time(7, 29);
    run(T * 60 - 1);
    check_val("t4_pre_sec", 32'(secunde), 32'd59);
    check_val("t4_pre_ring", 32'(sonerie), 32'd0);
    step();
    check_val("t4_match_min", 32'(minute), 32'd30);
    check_val("t4_match_ring", 32'(sonerie), 32'd1);
    run(T * D - 1);
    check_val("t4_still_ring", 32'(sonerie), 32'd1);
    step();
    check_val("t4_timeout", 32'(sonerie), 32'd0);
    run(T * 5);

    // Snooze, re-ring, then stop.
    load_time(7, 29);
    run(T * 60 + 6);
    semnal_amanare = 1'b1;
    step();
    semnal_amanare = 1'b0;
    check_val("t5_snoozed", 32'(sonerie), 32'd0);
    run(T * A + 6);
    semnal_oprire = 1'b1;
    step();
    semnal_oprire = 1'b0;
    check_val("t5_stopped", 32'(sonerie), 32'd0);
    run(T * 20);

    // Asynchronous reset while ringing, mid-second.
    load_time(7, 29);
    run(T * 60 + 2);
    load_timp = 1'b0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_val("t6_rst_ring", 32'(sonerie), 32'd0);
    check_val("t6_rst_ore", 32'(ore), 32'd0);
    compare_all();
    #2 reset = 1'b0;
    load_alarm(7, 30);
    load_time(7, 30);
    run(T * 10);
    check_val("t6_no_ring", 32'(sonerie), 32'd0);
    load_timp = 1'b0;

    // Randomized alarm episodes.
    for (int e = 0; e < 30; e++) begin
      int h, m;
      h = $urandom_range(0, 23);
      m = $urandom_range(1, 59);
      alarma_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) load_alarm($urandom_range(24, 31), m);
      else load_alarm(h, m);
      load_time(h, m - 1);
      load_timp = 1'b0;
      for (int c = 0; c < 400; c++) begin
        semnal_oprire  = ($urandom_range(0, 199) == 0);
        semnal_amanare = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 299) == 0) alarma_en = ~alarma_en;
        if ($urandom_range(0, 149) == 0) begin
          ore_in      = 5'($urandom_range(0, 31));
          minute_in   = 6'($urandom_range(0, 63));
          load_alarma = ~load_alarma;
        end
        if ($urandom_range(0, 399) == 0) load_timp = ~load_timp;
        step();
      end
      semnal_oprire  = 1'b0;
      semnal_amanare = 1'b0;
      load_alarma    = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
